dpram_port_arbiter: RTL
=======================

Name: dpram_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one port of the synchronous dual-port RAM between NUM_REQ requesters.
- Accepts at most one read or write per cycle and drives the RAM port through registered command outputs.
- Returns read data with a valid strobe and requester ID, aligned to the RAM's one-cycle read latency.
- One instance per RAM port; two instances give two independent requester groups.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of requester index; must satisfy 2**ID_WIDTH >= NUM_REQ.
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 4, RAM address width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- arb_en  in  1  when 0, no new grants; in-flight read still returns.
- req  in  NUM_REQ  per-requester request, held until granted.
- req_we  in  NUM_REQ  per-requester op: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same slicing.
- gnt  out  NUM_REQ  one-hot combinational acceptance, same cycle as req.
- ram_we  out  1  registered write enable to RAM port.
- ram_re  out  1  registered read enable to RAM port.
- ram_addr  out  ADDR_WIDTH  registered address.
- ram_wdata  out  DATA_WIDTH  registered write data.
- ram_rdata  in  DATA_WIDTH  RAM port data_out.
- rvalid  out  1  read data valid.
- rid  out  ID_WIDTH  index of requester owning rdata.
- rdata  out  DATA_WIDTH  read data, passed straight through from ram_rdata.

Behaviour:
- Reset (async): ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, rvalid=0, rid=0, priority pointer=0. gnt is 0 while reset is high. Any in-flight read is discarded; no rvalid is produced for it after reset releases.
- Arbitration (cycle N):
  - If arb_en=1 and req!=0, gnt selects the first set req bit searching from the pointer upward, with wrap from NUM_REQ-1 to 0.
  - Otherwise gnt=0.
  - Exactly one or zero bits of gnt are set.
- Pointer update: on a grant to i, the pointer becomes (i+1) mod NUM_REQ at the next edge. With no grant, the pointer holds.
- Handshake:
  - A request is consumed on the cycle gnt[i]=1.
  - Requester i may present a new op (or hold req) the following cycle; it will compete again from the updated pointer.
  - req_we, addr and wdata must be stable while req is high and ungranted.
- Issue (cycle N+1):
  - The granted op is registered: ram_we=req_we[i], ram_re=~req_we[i], with the granted addr and wdata.
  - Without a grant, ram_we=0 and ram_re=0. Addr and wdata hold their previous values.
- Read return (cycle N+2): rvalid=1 and rid=i, registered one stage after ram_re. rdata=ram_rdata (RAM output, valid that cycle).
- Throughput: one op per cycle sustained. Back-to-back reads return on consecutive cycles in grant order.
- Write-then-read from different requesters to the same address on consecutive grants returns the new data.
- arb_en low mid-stream: the issue/return pipeline drains normally; the pointer is frozen.
- Single requester continuously asserting req is granted every cycle.

Decomposition:
- Shared package/include holds the operation encoding constants (OP_READ=0, OP_WRITE=1) and the flattened-bus slice helper macros.
- One sub-module, rr_priority_picker: parameterised on NUM_REQ; inputs req and pointer, output one-hot grant and encoded index. Purely combinational.
- The arbiter wraps it with the pointer register, issue register and return-tag pipeline.

Test Plan:
- Reset then single read: req=4'b0001, req_we=0, addr0=3, RAM initial contents mem[3]=3 -> gnt=0001 cycle N; ram_re=1, ram_addr=3 at N+1; rvalid=1, rid=0, rdata=8'h03 at N+2.
- All four requesters reading continuously (addrs 1,2,3,4) -> gnts 0001,0010,0100,1000,0001 on consecutive cycles; rid sequence 0,1,2,3,0; rdata 1,2,3,4,1.
- Requester 2 writes 8'hA5 to addr 7, then requester 0 reads addr 7 next cycle -> ram_we at N+1, ram_re at N+2; rvalid with rid=0 and rdata=8'hA5 at N+3.
- arb_en=0 with req=4'b1111 for 3 cycles -> gnt=0, ram_we=ram_re=0; the pointer is unchanged. After arb_en=1, the first gnt goes to the pointer-selected requester.
- Assert reset one cycle after a read is granted -> all outputs 0 immediately. No rvalid follows. After reset, the pointer is 0, so requester 0 wins against req=4'b0101.
- Pointer wrap: last grant to 3, req=4'b1001 -> gnt=0001, then 1000.

Source files
------------

// File: rtl/dpram_port_arbiter_pkg.sv
// dpram_port_arbiter_pkg: op encoding shared by the arbiter, plus a flattened-bus slice macro
package dpram_port_arbiter_pkg;
   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;
endpackage

`ifndef DPA_SLICE
`define DPA_SLICE(bus, i, w) bus[(int'(i))*(w) +: (w)]
`endif

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first set req bit at or above ptr, wrapping
//   req : request vector
//   ptr : search start index
//   gnt : one-hot pick (zero when req is zero)
//   idx : encoded index of the pick
module rr_priority_picker
   import dpram_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]  gnt,
   output logic [ID_WIDTH-1:0] idx
);
   // Scan from farthest to nearest so the candidate closest to ptr is written last and wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % NUM_REQ]) begin
            gnt = NUM_REQ'(1) << ((int'(ptr) + k) % NUM_REQ);
            idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
         end
   end
endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of one synchronous RAM port among NUM_REQ requesters
//   arb_en                          : allow new grants
//   req/req_we/req_addr/req_wdata   : per-requester op, flattened buses
//   gnt                             : combinational one-hot acceptance
//   ram_we/ram_re/ram_addr/ram_wdata: registered RAM command
//   ram_rdata                       : RAM data_out (one-cycle read latency)
//   rvalid/rid/rdata                : read return tagged with requester index
module dpram_port_arbiter
   import dpram_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             arb_en,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               gnt,
   output logic                             ram_we,
   output logic                             ram_re,
   output logic [ADDR_WIDTH-1:0]            ram_addr,
   output logic [DATA_WIDTH-1:0]            ram_wdata,
   input  logic [DATA_WIDTH-1:0]            ram_rdata,
   output logic                             rvalid,
   output logic [ID_WIDTH-1:0]              rid,
   output logic [DATA_WIDTH-1:0]            rdata
);
   logic [ID_WIDTH-1:0] ptr, idx, iss_id;
   logic [NUM_REQ-1:0]  pick;
   logic                hit;

   rr_priority_picker #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
      .req(req),
      .ptr(ptr),
      .gnt(pick),
      .idx(idx)
   );

   assign gnt   = (arb_en && !reset) ? pick : '0;
   assign hit   = |gnt;
   assign rdata = ram_rdata;

   // iss_id tags the op sitting in the issue register so the read return knows its owner.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ptr       <= '0;
         iss_id    <= '0;
         ram_we    <= 1'b0;
         ram_re    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         rvalid    <= 1'b0;
         rid       <= '0;
      end else begin
         ram_we <= hit && req_we[idx] == OP_WRITE;
         ram_re <= hit && req_we[idx] == OP_READ;
         if (hit) begin
            ram_addr  <= `DPA_SLICE(req_addr, idx, ADDR_WIDTH);
            ram_wdata <= `DPA_SLICE(req_wdata, idx, DATA_WIDTH);
            iss_id    <= idx;
            ptr       <= idx == ID_WIDTH'(NUM_REQ - 1) ? '0 : idx + ID_WIDTH'(1);
         end
         rvalid <= ram_re;
         rid    <= ram_re ? iss_id : rid;
      end
endmodule
